// File: rtl/turbo_deinterleaver.sv
`timescale 1ns/1ps
// turbo_deinterleaver: collects one PB of interleaved symbol pairs, scatters
// them to natural-order addresses, then streams the whole PB out in order.
module turbo_deinterleaver #(
  parameter int unsigned L16     = 64,
  parameter int unsigned L136    = 544,
  parameter int unsigned L520    = 2080,
  parameter int unsigned STEP16  = 9,
  parameter int unsigned STEP136 = 27,
  parameter int unsigned STEP520 = 33
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] pb_size,
  input  logic [1:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic [1:0] dout,
  output logic       dout_vld,
  output logic       dout_last,
  output logic       err
);

  localparam int unsigned AW = 12;
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    mem [L520];
  logic [AW-1:0] len_q, step_q;
  logic [AW-1:0] len_sel, step_sel;
  logic          size_ok;
  logic [AW-1:0] waddr, wnext, wa;
  logic [AW:0]   wsum;
  logic [AW-1:0] cnt;
  logic [AW-1:0] raddr;
  logic          rd_go;
  logic          we;
  logic          last_beat;
  logic          rd_last;

  // Decode the requested PB size into length and permutation step
  always_comb begin
    len_sel  = '0;
    step_sel = '0;
    size_ok  = 1'b1;
    case (pb_size)
      2'b00: begin len_sel = AW'(L16);  step_sel = AW'(STEP16);  end
      2'b01: begin len_sel = AW'(L136); step_sel = AW'(STEP136); end
      2'b10: begin len_sel = AW'(L520); step_sel = AW'(STEP520); end
      default: size_ok = 1'b0;
    endcase
  end

  // Incremental (i*STEP) mod L; STEP < L so one conditional subtract suffices
  always_comb begin
    wsum  = {1'b0, waddr} + {1'b0, step_q};
    wnext = (wsum >= {1'b0, len_q}) ? AW'(wsum - {1'b0, len_q}) : wsum[AW-1:0];
    we    = din_vld && (((state == IDLE) && size_ok) || (state == WRITE));
    wa    = (state == WRITE) ? waddr : '0;
    last_beat = (cnt == len_q - ONE);
    rd_last   = rd_go && (raddr == len_q - ONE);
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and ready decode
  always_comb begin
    state_nxt = state;
    din_rdy   = 1'b1;
    case (state)
      IDLE:  if (din_vld && size_ok) state_nxt = WRITE;
      WRITE: if (din_vld && last_beat) state_nxt = READ;
      READ: begin
        din_rdy = 1'b0;
        if (rd_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer write port; contents are deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= din;
  end

  // Counters, addresses, registered read data and error pulse.
  // READ spends its first cycle arming rd_go so the last output lands in the
  // same cycle the FSM returns to IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_q     <= '0;
      step_q    <= '0;
      waddr     <= '0;
      cnt       <= '0;
      raddr     <= '0;
      rd_go     <= 1'b0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      err       <= 1'b0;
    end else begin
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (din_vld) begin
            if (size_ok) begin
              len_q  <= len_sel;
              step_q <= step_sel;
              waddr  <= step_sel;
              cnt    <= ONE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (din_vld) begin
            if (last_beat) begin
              cnt   <= '0;
              waddr <= '0;
            end else begin
              cnt   <= cnt + ONE;
              waddr <= wnext;
            end
          end
        end
        READ: begin
          if (din_vld) err <= 1'b1;
          if (!rd_go) begin
            rd_go <= 1'b1;
          end else begin
            dout      <= mem[raddr];
            dout_vld  <= 1'b1;
            dout_last <= rd_last;
            if (rd_last) begin
              raddr <= '0;
              rd_go <= 1'b0;
            end else begin
              raddr <= raddr + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
